// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding,
// default burst cap and the owner-index width helper.
package fifo_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Default cap on words granted to one requester per arbitration.
  localparam int MAX_BURST_DEF = 4;

  // Owner index width; never narrower than one bit.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first set request bit found when
// scanning upward from rr_last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // w_pos[gi] is the requester visited at scan step gi (step 0 = rr_last+1).
  logic [IDX_W-1:0] w_pos [NREQ];
  logic [NREQ-1:0]  w_hit;
  logic [NREQ:0]    w_found;
  logic [IDX_W-1:0] w_idx_chain [NREQ+1];

  assign w_found[0]     = 1'b0;
  assign w_idx_chain[0] = '0;

  // Priority chain: only the first hit along the scan order contributes its index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
    assign w_pos[gi]           = IDX_W'((32'(rr_last) + 32'(gi) + 32'd1) % 32'(NREQ));
    assign w_hit[gi]           = req[w_pos[gi]];
    assign w_found[gi+1]       = w_found[gi] | w_hit[gi];
    assign w_idx_chain[gi+1]   = w_idx_chain[gi] |
                                 ({IDX_W{w_hit[gi] & ~w_found[gi]}} & w_pos[gi]);
  end

  assign idx = w_idx_chain[NREQ];
  assign any = w_found[NREQ];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NREQ producers.
// A grant lasts up to MAX_BURST accepted words, until the owner's last word,
// or until the owner withdraws; every write is gated by the FIFO full flag.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int IDX_W     = clog2_w(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       last_i,
  input  logic [NREQ*WIDTH-1:0] wdata_i,
  input  logic                  fifo_full_i,
  output logic [NREQ-1:0]       gnt_out,
  output logic                  fifo_write_en_out,
  output logic [WIDTH-1:0]      fifo_wdata_out,
  output logic [IDX_W-1:0]      owner_out,
  output logic                  busy_out
);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_owner, w_owner_next;
  logic [IDX_W-1:0] r_rr_last, w_rr_last_next;
  logic [3:0]       r_beat_cnt, w_beat_cnt_next;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_busy;
  logic             w_req_own;
  logic             w_last_own;
  logic             w_acc;
  logic             w_cap;
  logic [WIDTH-1:0] w_lane [NREQ];

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req_i),
    .rr_last (r_rr_last),
    .idx     (w_pick_idx),
    .any     (w_pick_any)
  );

  assign w_busy     = (r_state == ST_BURST);
  assign w_req_own  = req_i[r_owner];
  assign w_last_own = last_i[r_owner];
  // A word moves only when the owner offers it, the FIFO has room, and reset
  // is not asserted (reset mid-burst must not leak a write).
  assign w_acc      = rst_i & w_busy & w_req_own & ~fifo_full_i;
  // Current word is the MAX_BURST-th of this grant.
  assign w_cap      = (r_beat_cnt == 4'(MAX_BURST - 1));

  // Unpack per-requester data lanes and build the one-hot grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_lane[gi]  = wdata_i[gi*WIDTH +: WIDTH];
    assign gnt_out[gi] = w_acc & (r_owner == IDX_W'(gi));
  end

  assign fifo_write_en_out = w_acc;
  assign fifo_wdata_out    = w_busy ? w_lane[r_owner] : '0;
  assign owner_out         = r_owner;
  assign busy_out          = w_busy;

  // Next-state logic: arbitrate in IDLE, count beats and decide release in BURST.
  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_beat_cnt_next = r_beat_cnt;
    w_rr_last_next  = r_rr_last;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_owner_next    = w_pick_idx;
          w_beat_cnt_next = '0;
          w_state_next    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!w_req_own) begin
          // Owner withdrew: release without writing.
          w_state_next   = ST_IDLE;
          w_rr_last_next = r_owner;
        end else if (w_acc) begin
          w_beat_cnt_next = r_beat_cnt + 4'd1;
          if (w_last_own || w_cap) begin
            w_state_next   = ST_IDLE;
            w_rr_last_next = r_owner;
          end
        end
        // Otherwise the FIFO is full: hold with the beat count frozen.
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; rr_last starts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_rr_last  <= IDX_W'(NREQ - 1);
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_rr_last  <= w_rr_last_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers, a 16-deep FIFO and a grant-level
// reference model live here; directed phases then a randomized end-to-end run.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 32;
  localparam int MAXB = 4;
  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       last;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  full;
  logic [NREQ-1:0]       gnt;
  logic                  we;
  logic [WIDTH-1:0]      wd;
  logic [1:0]            owner;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAXB),
    .IDX_W     (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .req_i             (req),
    .last_i            (last),
    .wdata_i           (wdata),
    .fifo_full_i       (full),
    .gnt_out           (gnt),
    .fifo_write_en_out (we),
    .fifo_wdata_out    (wd),
    .owner_out         (owner),
    .busy_out          (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Producer state
  int sent [NREQ];
  int total [NREQ];
  int pkt_len;
  logic [NREQ-1:0] mask;
  int prob;

  // FIFO / reader state
  logic [31:0] fq [$];
  logic force_full;
  int rd_prob;
  int rd_seq [NREQ];
  int popped;

  // Reference model: a grant is either open (with owner and words taken) or not.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_words = 0;
  int m_prev = NREQ - 1;

  // Observation logs
  int grant_log [$];
  int groups [$];
  int run_len = 0;
  logic obs_busy;
  logic [NREQ-1:0] obs_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k, input int s);
    return {8'(k), 24'(s)};
  endfunction

  function automatic bit all_sent();
    for (int k = 0; k < NREQ; k++)
      if (sent[k] < total[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req[k]  = mask[k] && (sent[k] < total[k]) && ($urandom_range(99) < 32'(prob));
      last[k] = (((sent[k] + 1) % pkt_len) == 0) || (sent[k] + 1 == total[k]);
      wdata[k*WIDTH +: WIDTH] = word(k, sent[k]);
    end
    full = force_full | (fq.size() >= DEPTH);
  endtask

  task automatic release_grant();
    m_busy = 1'b0;
    m_prev = m_owner;
  endtask

  // One clock: drive at negedge, compare after settling, update models at posedge.
  task automatic cycle();
    bit e_acc;
    int ow;
    int k;
    logic [31:0] w;
    drive();
    #1;
    e_acc = rst_n && m_busy && req[m_owner] && !full;
    chk("gnt", 32'(gnt), e_acc ? 32'(1 << m_owner) : 32'd0);
    chk("write_en", 32'(we), 32'(e_acc));
    chk("wdata", wd, m_busy ? word(m_owner, sent[m_owner]) : 32'd0);
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
    obs_busy = busy;
    obs_gnt = gnt;
    if (we) begin
      run_len++;
      ow = 0;
      for (int j = 0; j < NREQ; j++) if (gnt[j]) ow = j;
      grant_log.push_back(ow);
    end else if (run_len > 0) begin
      groups.push_back(run_len);
      run_len = 0;
    end
    @(posedge clk);
    // Reader pops first so a word written this edge is not readable yet.
    if (fq.size() > 0 && $urandom_range(99) < 32'(rd_prob)) begin
      w = fq.pop_front();
      k = int'(w[31:24]);
      popped++;
      if (k < NREQ) begin
        chk("fifo_order", 32'(w[23:0]), 32'(rd_seq[k]));
        rd_seq[k]++;
      end else begin
        chk("fifo_src", 32'(k), 32'(NREQ - 1));
      end
    end
    if (e_acc) begin
      fq.push_back(word(m_owner, sent[m_owner]));
      sent[m_owner]++;
    end
    if (!rst_n) begin
      m_busy = 1'b0;
      m_owner = 0;
      m_words = 0;
      m_prev = NREQ - 1;
    end else if (!m_busy) begin
      for (int j = 1; j <= NREQ; j++) begin
        if (req[(m_prev + j) % NREQ]) begin
          m_owner = (m_prev + j) % NREQ;
          m_busy = 1'b1;
          m_words = 0;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      release_grant();
    end else if (e_acc) begin
      m_words++;
      if (last[m_owner] || m_words == MAXB) release_grant();
    end
    @(negedge clk);
  endtask

  task automatic new_phase();
    fq.delete();
    grant_log.delete();
    groups.delete();
    run_len = 0;
    popped = 0;
    for (int k = 0; k < NREQ; k++) begin
      sent[k] = 0;
      total[k] = 0;
      rd_seq[k] = 0;
    end
  endtask

  initial begin
    force_full = 1'b0;
    rd_prob = 100;
    prob = 100;
    pkt_len = 1;
    mask = 4'b1111;
    new_phase();
    for (int k = 0; k < NREQ; k++) total[k] = 100;

    // Reset with all requesters asserting.
    rst_n = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    repeat (2) cycle();
    chk("reset_gnt", 32'(obs_gnt), 32'd0);
    rst_n = 1'b1;

    // Fairness: one-word packets from everyone, FIFO drained every cycle.
    repeat (10) cycle();
    chk("fair_count", grant_log.size(), 5);
    if (grant_log.size() >= 5) begin
      chk("fair_0", grant_log[0], 0);
      chk("fair_1", grant_log[1], 1);
      chk("fair_2", grant_log[2], 2);
      chk("fair_3", grant_log[3], 3);
      chk("fair_4", grant_log[4], 0);
    end

    // Burst cap: requester 2 alone, one 10-word packet.
    new_phase();
    mask = 4'b0100;
    total[2] = 10;
    pkt_len = 10;
    repeat (16) cycle();
    chk("cap_writes", grant_log.size(), 10);
    chk("cap_groups", groups.size(), 3);
    if (groups.size() == 3) begin
      chk("cap_g0", groups[0], 4);
      chk("cap_g1", groups[1], 4);
      chk("cap_g2", groups[2], 2);
    end

    // Withdraw: 3 wins (rr_last=2), sends one word, drops; 0 is then granted.
    new_phase();
    total[0] = 50;
    total[3] = 50;
    pkt_len = 50;
    mask = 4'b1001;
    repeat (2) cycle();
    mask = 4'b0001;
    repeat (3) cycle();
    chk("wd_gnt", 32'(obs_gnt), 32'b0001);
    chk("wd_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("wd_first", grant_log[0], 3);
      chk("wd_second", grant_log[1], 0);
    end
    mask = 4'b0000;
    repeat (2) cycle();

    // Full stall: owner 1 blocked for 3 cycles mid-burst.
    new_phase();
    mask = 4'b0010;
    total[1] = 8;
    pkt_len = 8;
    repeat (3) cycle();
    chk("stall_pre", grant_log.size(), 2);
    force_full = 1'b1;
    repeat (3) cycle();
    chk("stall_hold", grant_log.size(), 2);
    force_full = 1'b0;
    cycle();
    chk("stall_resume", grant_log.size(), 3);
    repeat (10) cycle();
    chk("stall_total", grant_log.size(), 8);
    chk("stall_popped", popped, 8);

    // End-to-end: random requests, slow random reader, reset mid-run.
    new_phase();
    mask = 4'b1111;
    for (int k = 0; k < NREQ; k++) total[k] = 20;
    pkt_len = 3;
    prob = 70;
    rd_prob = 35;
    for (int c = 0; c < 4000 && !all_sent(); c++) begin
      rst_n = (c != 150);
      cycle();
      if (c == 151) chk("mid_reset_busy", 32'(obs_busy), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) chk("e2e_sent", sent[k], 20);
    mask = 4'b0000;
    rd_prob = 100;
    for (int c = 0; c < 60 && fq.size() > 0; c++) cycle();
    chk("e2e_popped", popped, 80);
    chk("e2e_empty", fq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `sync_fifo` write port among `NREQ` producers. It grants the port to one requester at a time for a burst of up to `MAX_BURST` words or until that requester marks its last word. It gates every write with the FIFO's `full_out`, so no word is ever offered to a full FIFO. It sits directly in front of `sync_fifo`: `fifo_write_en_out`/`fifo_wdata_out` drive its `write_en_i`/`wdata_i`, and its `full_out` returns as `fifo_full_i`.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, data width; matches `sync_fifo` `WIDTH`
- `MAX_BURST`, 4, maximum words per grant (1..15)
- `IDX_W`, 2, owner index width, clog2(`NREQ`)
- `clk_i`  input  1  clock; all state updates on posedge
- `rst_i`  input  1  synchronous, active-low reset
- `req_i`  input  `NREQ`  per-requester word-valid
- `last_i`  input  `NREQ`  per-requester last-word-of-packet flag, qualified by `req_i`
- `wdata_i`  input  `NREQ*WIDTH`  packed data; requester k occupies bits [k*WIDTH +: WIDTH]
- `fifo_full_i`  input  1  `sync_fifo` `full_out`
- `gnt_out`  output  `NREQ`  one-hot; word of requester k accepted this cycle
- `fifo_write_en_out`  output  1  FIFO write strobe
- `fifo_wdata_out`  output  `WIDTH`  FIFO write data
- `owner_out`  output  `IDX_W`  current or most recent owner index
- `busy_out`  output  1  high while in BURST

## Operation
- States: IDLE, BURST.
- Registered state: `state`, `owner`, `beat_cnt` (4 bits), `rr_last` (index of last owner).
- **IDLE:**
  - If any `req_i` bit is set, select the first set bit scanning from `rr_last+1` upward, modulo `NREQ`.
  - Load `owner` with that index and clear `beat_cnt`; go to BURST.
  - If no `req_i` bit is set, stay in IDLE.
  - No write occurs in IDLE.
- **BURST:**
  - Accept condition: `acc = req_i[owner] & ~fifo_full_i`.
  - Combinational outputs: `fifo_write_en_out = acc`, `gnt_out = acc << owner`, `fifo_wdata_out = wdata_i[owner]`.
  - `fifo_wdata_out` is 0 when not in BURST.
  - On `acc`, increment `beat_cnt`.
  - Go to IDLE and set `rr_last <= owner` when any of the following holds:
    - `acc & last_i[owner]`
    - `acc & (beat_cnt == MAX_BURST-1)`, a forced release; the packet resumes on a later grant
    - `~req_i[owner]`, the owner withdrew; no write that cycle
  - Full stall: `req_i[owner]=1` with `fifo_full_i=1` holds BURST with no write and `beat_cnt` unchanged.
- Requesters hold data stable while `req_i` is high and the word is not yet granted.
- No word is duplicated or dropped.
- `owner_out = owner`; `busy_out = (state==BURST)`.

## Timing
- **Reset** (`rst_i=0` at posedge):
  - Internal state: `state=IDLE`, `owner=0`, `beat_cnt=0`, `rr_last=NREQ-1`, so requester 0 has top priority first.
  - Outputs: `gnt_out=0`, `fifo_write_en_out=0`, `fifo_wdata_out=0`, `owner_out=0`, `busy_out=0`.
  - Reset mid-burst abandons the burst with no write that cycle.
  - Reset overrides all inputs.
- **Arbitration latency:** one IDLE cycle per grant. A request seen at posedge N in IDLE can write at the earliest in cycle N+1.
- **Peak throughput:** `MAX_BURST` words per `MAX_BURST+1` cycles.
- **Full:** `fifo_full_i` is used combinationally in the same cycle. Because `sync_fifo` updates full after the write edge, a write is never issued while full is high. When the FIFO reads and full clears, writing resumes in that same cycle.
- **Last word at cap:** `last_i` on the `MAX_BURST`-th word counts as one release. There is no extra IDLE.
- **Single requester:** re-granted after each IDLE cycle. With `NREQ`=1-equivalent traffic, that requester wins every arbitration.
- **New requests:** arrivals during BURST are evaluated at the next IDLE only.

## Structure
- Shared package `fifo_pkg`: `IDX_W` derivation function (clog2), state encoding constants `ST_IDLE=0` and `ST_BURST=1`, `MAX_BURST` default.
- One natural sub-module: `rr_pick`, a combinational rotate-priority encoder.
  - Inputs: `req`, `rr_last`.
  - Outputs: `idx`, `any`.
- The rest lives in `fifo_wr_arbiter`: FSM, counter, data mux, gating.

## Test plan
- **Reset:** `rst_i=0` for 2 cycles with all `req_i=4'b1111` → all outputs 0. After release, the first grant goes to owner 0.
- **Fairness:** `req_i=4'b1111`, `last_i` always set, FIFO never full → grant order 0,1,2,3,0. Exactly one write every 2 cycles, and `fifo_wdata_out` matches the owner's `wdata_i`.
- **Burst cap:** requester 2 alone, 10-word packet with `last_i` on word 10 → writes in groups of 4,4,2 separated by one idle cycle. 10 writes total, in order.
- **Full stall:** during a BURST of owner 1, `fifo_full_i=1` for 3 cycles → `fifo_write_en_out=0` and `beat_cnt` frozen. Writing resumes the cycle full drops, with no lost or duplicated word.
- **Withdraw:** owner 3 drops `req_i[3]` after 1 word while requester 0 is waiting → return to IDLE, then grant 0 with `rr_last=3`.
- **End-to-end:** connect to `sync_fifo` (`DEPTH`=16), 4 requesters × 20 words each, random `req_i`, reader randomly idle → the FIFO receives all 80 words. Each requester's words stay in order, `gnt_out` is never set while `fifo_full_i`=1, and reset mid-run clears `busy_out`.
